load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the word-wide data memory port; sits between the CPU memory stage and the data memory.
- Accepts byte, halfword and word load/store requests from the core through a valid/ready handshake.
- Drives word-aligned address, write data and write strobe to the memory; the memory reads combinationally and writes on the clock edge.
- Builds sub-word stores as read-modify-write sequences and sign- or zero-extends sub-word loads.

Parameters:
- ADDR_WIDTH, 32, byte-address width for the request and memory address.
- DATA_WIDTH, 32, data width. Only 32 is supported; the design asserts this at elaboration.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend loads when 1; sign-extend when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal size.
- mem_address  out  ADDR_WIDTH  word address with bits [1:0] = 00.
- mem_data  out  DATA_WIDTH  write word.
- mem_write  out  1  write strobe for one cycle.
- mem_read_data  in  DATA_WIDTH  combinational read word, little-endian (byte 0 = bits [7:0]).

Behaviour:
- States: IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
- Reset: state = IDLE. Outputs: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_write = 0, mem_address = 0, mem_data = 0.
- Accept: when req_valid && req_ready in cycle T, latch addr, size, unsigned flag and wdata. Then branch:
  - error → RESP
  - load → LOAD
  - word store → STORE_W
  - byte or half store → RMW_RD
- Error condition:
  - size = 11, or
  - half with addr[0] = 1, or
  - word with addr[1:0] != 00.
  - No memory access occurs; resp_valid is high at T+1 with resp_err = 1.
- LOAD (T+1): drive mem_address. Capture mem_read_data, extract the lane selected by addr[1:0], extend, and register. resp_valid is high at T+2.
- STORE_W (T+1): mem_write = 1, mem_data = wdata. resp_valid is high at T+2.
- RMW_RD (T+1): capture the old word from mem_read_data.
- RMW_WR (T+2): mem_write = 1. mem_data = old word with the addressed byte or half lanes replaced by wdata[7:0] or wdata[15:0]. resp_valid is high at T+3.
- mem_write is asserted only in STORE_W and RMW_WR. It is never high for more than one cycle per request.
- RESP:
  - Hold resp_valid, resp_rdata and resp_err stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE. req_ready rises the following cycle; no back-to-back accept in the same cycle.
- mem_address holds the latched word address from LOAD/RMW_RD until IDLE. It is 0 in IDLE.
- Reset mid-operation: go to IDLE next cycle with the reset output values. A pending RMW write is dropped, and mem_write is never asserted in the reset cycle.
- Address bits above bit 15 are passed through unchanged; the memory's range is the memory's concern.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
  - Defined: misaligned accesses raise resp_err as described above.
  - Undefined: misaligned half/word accesses are silently aligned down (half to addr[1], word to 00) and proceed normally with resp_err = 0. Size 11 still errors.

Decomposition:
- lsu_pkg:
  - size enum: SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum.
  - WORD_BYTES = 4 constant.
- Sub-module lsu_byte_lane (combinational):
  - extract: word, offset, size, unsigned → extended data.
  - merge: old word, wdata, offset, size → new word.
  - Instantiated once in load_store_unit.

Test Plan:
- Word store, then load: store 0xDEADBEEF @0x100; mem_write high one cycle at T+1, mem_address = 0x100. Load word @0x100 returns 0xDEADBEEF, resp_valid at T+2, err = 0.
- Byte load sign/zero: mem word 0x80F17F00 @0x200.
  - Signed byte @0x203 → 0xFFFFFF80.
  - Unsigned byte @0x203 → 0x00000080.
  - Signed half @0x202 → 0xFFFF80F1.
- Sub-word RMW store: word 0x11223344 @0x300.
  - sb 0xAA @0x301: write at T+2 of 0x1122AA44, resp at T+3.
  - Then sh 0xBEEF @0x302 → 0xBEEFAA44.
- Misaligned with LSU_MISALIGN_TRAP_EN: lw @0x105 → resp_err = 1 at T+1, mem_write never asserted. Without the macro, it reads word @0x104.
- Backpressure: hold resp_ready = 0 for 5 cycles → resp_valid and resp_rdata stable, req_ready = 0, no memory write. Release → IDLE, req_ready = 1 on the next cycle.
- Reset during RMW: assert rst in the RMW_RD cycle of sb @0x301 → memory word is unchanged. Next cycle: IDLE, req_ready = 1, resp_valid = 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states and
// lane-alignment helpers used by load_store_unit and lsu_byte_lane.
package lsu_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = WORD_BYTES * 8;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE_W,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_e;

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Rounds the byte offset down to the natural boundary of the access size.
    function automatic logic [1:0] align_offset(input lsu_size_e size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return {lo[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends a sub-word from a read word, and
// merges sub-word store data into an old word for read-modify-write.
import lsu_pkg::*;

module lsu_byte_lane (
    input  logic [WORD_BITS-1:0] rd_word,
    input  logic [WORD_BITS-1:0] old_word,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic [1:0]           offset,
    input  lsu_size_e            size,
    input  logic                 is_unsigned,
    output logic [WORD_BITS-1:0] ext_data,
    output logic [WORD_BITS-1:0] merged_word
);

    logic [WORD_BITS-1:0] shifted;

    assign shifted = rd_word >> {offset, 3'b000};

    always_comb begin
        ext_data = rd_word;
        case (size)
            SZ_BYTE: ext_data = is_unsigned ? {24'h000000, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ext_data = is_unsigned ? {16'h0000, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: ext_data = rd_word;
        endcase
    end

    // Half merges use only offset[1]; the offset is already aligned for halves.
    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: merged_word[{offset, 3'b000} +: 8]      = wdata[7:0];
            SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide data memory with sub-word RMW stores.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses error instead of aligning down.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    if (DATA_WIDTH != WORD_BITS) begin : g_bad_width
        $error("load_store_unit supports only DATA_WIDTH = 32");
    end

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    lsu_size_e             size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] old_word_q, old_word_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    lsu_size_e             req_size_e;
    logic                  req_err;
    logic                  accept;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign req_size_e = lsu_size_e'(req_size);
    assign accept     = (state_q == ST_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = (req_size_e == SZ_ILLEGAL) || is_misaligned(req_size_e, req_addr[1:0]);
`else
    assign req_err = (req_size_e == SZ_ILLEGAL);
`endif

    lsu_byte_lane u_lane (
        .rd_word     (mem_read_data),
        .old_word    (old_word_q),
        .wdata       (wdata_q),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .ext_data    (ext_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                     state_d = ST_RESP;
                    else if (!req_write)             state_d = ST_LOAD;
                    else if (req_size_e == SZ_WORD)  state_d = ST_STORE_W;
                    else                             state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:    state_d = ST_RESP;
            ST_STORE_W: state_d = ST_RESP;
            ST_RMW_RD:  state_d = ST_RMW_WR;
            ST_RMW_WR:  state_d = ST_RESP;
            ST_RESP:    if (resp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            old_word_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            old_word_q <= old_word_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // The latched address is already aligned down, so only trapping builds ever see misalignment.
    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        old_word_d = old_word_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (accept) begin
            addr_d     = {req_addr[ADDR_WIDTH-1:2], align_offset(req_size_e, req_addr[1:0])};
            size_d     = req_size_e;
            unsigned_d = req_unsigned;
            wdata_d    = req_wdata;
            rdata_d    = '0;
            err_d      = req_err;
        end
        if (state_q == ST_LOAD)   rdata_d    = ext_data;
        if (state_q == ST_RMW_RD) old_word_d = mem_read_data;
    end

    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        resp_valid  = (state_q == ST_RESP);
        resp_rdata  = resp_valid ? rdata_q : '0;
        resp_err    = resp_valid && err_q;
        mem_address = ((state_q != ST_IDLE) && !err_q) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_write   = !rst && ((state_q == ST_STORE_W) || (state_q == ST_RMW_WR));
        mem_data    = '0;
        if (mem_write) begin
            mem_data = (state_q == ST_STORE_W) ? wdata_q : merged_word;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory model.
// Misaligned-access expectations follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:1023];
    int n_cmp;
    int n_fail;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_write     (mem_write),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[11:2]] <= mem_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request from an IDLE negedge; returns at the negedge inside cycle T+1.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h200 >> 2] = 32'h80F17F00;
        mem[32'h300 >> 2] = 32'h11223344;
        mem[32'h104 >> 2] = 32'hCAFEF00D;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_req_ready",  32'(req_ready),  32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata,      32'd0);
        checkOutput("rst_resp_err",   32'(resp_err),   32'd0);
        checkOutput("rst_mem_write",  32'(mem_write),  32'd0);
        checkOutput("rst_mem_addr",   mem_address,     32'd0);
        checkOutput("rst_mem_data",   mem_data,        32'd0);

        $display("[TB] word store then load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        checkOutput("sw_t1_mem_write", 32'(mem_write),  32'd1);
        checkOutput("sw_t1_mem_addr",  mem_address,     32'h100);
        checkOutput("sw_t1_mem_data",  mem_data,        32'hDEADBEEF);
        checkOutput("sw_t1_resp",      32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("sw_t2_resp",      32'(resp_valid), 32'd1);
        checkOutput("sw_t2_err",       32'(resp_err),   32'd0);
        checkOutput("sw_t2_rdata",     resp_rdata,      32'd0);
        checkOutput("sw_t2_mem_write", 32'(mem_write),  32'd0);
        checkOutput("sw_mem_word",     mem[32'h100 >> 2], 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("sw_idle_ready",   32'(req_ready),  32'd1);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checkOutput("lw_t1_resp",      32'(resp_valid), 32'd0);
        checkOutput("lw_t1_mem_addr",  mem_address,     32'h100);
        checkOutput("lw_t1_mem_write", 32'(mem_write),  32'd0);
        @(negedge clk);
        checkOutput("lw_t2_resp",      32'(resp_valid), 32'd1);
        checkOutput("lw_t2_rdata",     resp_rdata,      32'hDEADBEEF);
        checkOutput("lw_t2_err",       32'(resp_err),   32'd0);
        @(negedge clk);

        $display("[TB] sub-word loads");
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
        @(negedge clk);
        checkOutput("lb_signed",   resp_rdata, 32'hFFFFFF80);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
        @(negedge clk);
        checkOutput("lbu",         resp_rdata, 32'h00000080);
        @(negedge clk);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
        @(negedge clk);
        checkOutput("lh_signed",   resp_rdata, 32'hFFFF80F1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h201, 32'h0);
        @(negedge clk);
        checkOutput("lb_positive", resp_rdata, 32'h0000007F);
        @(negedge clk);

        $display("[TB] sub-word RMW stores");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AA);
        checkOutput("sb_t1_mem_write", 32'(mem_write),  32'd0);
        checkOutput("sb_t1_mem_addr",  mem_address,     32'h300);
        @(negedge clk);
        checkOutput("sb_t2_mem_write", 32'(mem_write),  32'd1);
        checkOutput("sb_t2_mem_data",  mem_data,        32'h1122AA44);
        checkOutput("sb_t2_resp",      32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("sb_t3_resp",      32'(resp_valid), 32'd1);
        checkOutput("sb_t3_mem_write", 32'(mem_write),  32'd0);
        checkOutput("sb_mem_word",     mem[32'h300 >> 2], 32'h1122AA44);
        @(negedge clk);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000BEEF);
        @(negedge clk);
        checkOutput("sh_t2_mem_data",  mem_data,        32'hBEEFAA44);
        @(negedge clk);
        checkOutput("sh_mem_word",     mem[32'h300 >> 2], 32'hBEEFAA44);
        @(negedge clk);

        $display("[TB] misaligned and illegal size");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h105, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("mis_t1_resp",      32'(resp_valid), 32'd1);
        checkOutput("mis_t1_err",       32'(resp_err),   32'd1);
        checkOutput("mis_t1_rdata",     resp_rdata,      32'd0);
        checkOutput("mis_t1_mem_write", 32'(mem_write),  32'd0);
`else
        checkOutput("mis_t1_resp",      32'(resp_valid), 32'd0);
        checkOutput("mis_t1_mem_addr",  mem_address,     32'h104);
        @(negedge clk);
        checkOutput("mis_t2_rdata",     resp_rdata,      32'hCAFEF00D);
        checkOutput("mis_t2_err",       32'(resp_err),   32'd0);
`endif
        @(negedge clk);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678);
        checkOutput("ill_t1_resp",      32'(resp_valid), 32'd1);
        checkOutput("ill_t1_err",       32'(resp_err),   32'd1);
        checkOutput("ill_t1_mem_write", 32'(mem_write),  32'd0);
        @(negedge clk);
        checkOutput("ill_mem_word",     mem[32'h100 >> 2], 32'hDEADBEEF);

        $display("[TB] response backpressure");
        resp_ready = 1'b0;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp_rdata",      resp_rdata,      32'hDEADBEEF);
            checkOutput("bp_req_ready",  32'(req_ready),  32'd0);
            checkOutput("bp_mem_write",  32'(mem_write),  32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_rel_req_ready",  32'(req_ready),  32'd1);
        checkOutput("bp_rel_resp_valid", 32'(resp_valid), 32'd0);

        $display("[TB] reset during RMW");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h301, 32'h00000055);
        rst = 1'b1;
        checkOutput("rrmw_rst_mem_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rrmw_req_ready",  32'(req_ready),  32'd1);
        checkOutput("rrmw_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rrmw_mem_write",  32'(mem_write),  32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rrmw_mem_word",   mem[32'h300 >> 2], 32'hBEEFAA44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
